// File: rtl/noc_client_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : noc_client_gen_if                                         |
// | Purpose  : Router-port bundle between a NoC endpoint and its router. |
// |            master = endpoint side, slave = router side.              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface noc_client_gen_if #(
   parameter int A_W = 3,
   parameter int D_W = 32
);
   logic [A_W+D_W:0] c_i;
   logic             c_i_v;
   logic             c_i_bp;
   logic [A_W+D_W:0] c_o;
   logic             c_o_v;
   logic             c_o_bp;

   modport master (
      input  c_i, c_i_v, c_o_bp,
      output c_i_bp, c_o, c_o_v
   );

   modport slave (
      output c_i, c_i_v, c_o_bp,
      input  c_i_bp, c_o, c_o_v
   );
endinterface
`default_nettype wire

// File: rtl/noc_client_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : noc_client_gen                                            |
// | Purpose  : LFSR-driven traffic generator and sink for one NoC PE.    |
// |            Packets go through a small injection FIFO and a single    |
// |            output register that holds stable under backpressure.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module noc_client_gen #(
   parameter int          N     = 4,
   parameter int          D_W   = 32,
   parameter int          A_W   = $clog2(N) + 1,
   parameter int          POSX  = 0,
   parameter int          PAT   = 0,
   parameter int          RATE  = 26,
   parameter int          LIMIT = 16,
   parameter int          SIGMA = 4,
   parameter int          DEPTH = 4,
   parameter logic [31:0] SEED  = 32'h1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   noc_client_gen_if.master bus,
   output logic [31:0]      sent_cnt,
   output logic [31:0]      rcvd_cnt,
   output logic             err,
   output logic             done
);
   localparam int              c_PW       = A_W + D_W + 1;
   localparam int              c_PTR_W    = $clog2(DEPTH);
   localparam logic [1:0]      S_IDLE     = 2'd0;
   localparam logic [1:0]      S_RUN      = 2'd1;
   localparam logic [1:0]      S_DRAIN    = 2'd2;
   localparam logic [1:0]      S_DONE     = 2'd3;
   localparam logic [31:0]     c_LFSR_MSK = 32'h8020_0003;  // taps 32,22,2,1
   localparam logic [63:0]     c_BASE     = 64'(POSX * LIMIT);
   localparam logic [31:0]     c_LIMIT    = 32'(LIMIT);
   localparam logic [8:0]      c_RATE     = 9'(RATE);
   localparam logic [31:0]     c_POSV     = 32'(POSX);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
   localparam logic [c_PTR_W:0]   c_CNT_ONE = 1;
   localparam logic [c_PTR_W:0]   c_CNT_MAX = (c_PTR_W+1)'(DEPTH);

   logic [1:0]          r_state;
   logic [31:0]         r_lfsr;
   logic [31:0]         r_att;
   logic [31:0]         r_sent;
   logic [31:0]         r_rcvd;
   logic                r_err;
   logic                r_done;
   logic [c_PW-1:0]     r_c_o;
   logic                r_c_o_v;
   logic [A_W+D_W-1:0]  r_mem [DEPTH];
   logic [c_PTR_W-1:0]  r_wp;
   logic [c_PTR_W-1:0]  r_rp;
   logic [c_PTR_W:0]    r_cnt;

   logic [31:0]         w_rnd;
   logic [31:0]         w_off;
   logic [31:0]         w_rev;
   logic [31:0]         w_pick;
   logic signed [31:0]  w_loc;
   logic [A_W-1:0]      w_dest;
   logic [D_W-1:0]      w_data;
   logic                w_full;
   logic                w_empty;
   logic                w_load;
   logic                w_deq;
   logic                w_hs;
   logic                w_rate_hit;
   logic                w_attempt;
   logic                w_go;
   logic                w_unused_ci;

   // Destination for the current LFSR value under the selected pattern
   always_comb begin
      w_rnd = 32'(r_lfsr[15:8]) % 32'(N);
      w_off = 32'(r_lfsr[23:16]) % 32'(SIGMA);
      w_loc = POSX + $signed(w_off) - SIGMA / 2;
      if (w_loc < 0) begin
         w_loc = 0;
      end else if (w_loc > N - 1) begin
         w_loc = N - 1;
      end
      w_rev = '0;
      for (int i = 0; i < A_W - 1; i++) begin
         w_rev[i] = c_POSV[A_W-2-i];
      end
      w_rev = w_rev % 32'(N);
      case (PAT)
         0:       w_pick = w_rnd;
         1:       w_pick = 32'(w_loc);
         2:       w_pick = w_rev;
         default: w_pick = 32'((POSX + N / 2 - 1) % N);
      endcase
      // never target ourselves
      if (w_pick == c_POSV) begin
         w_pick = 32'((POSX + 1) % N);
      end
      w_dest = A_W'(w_pick);
   end

   assign w_data     = D_W'(c_BASE + 64'(r_att));
   assign w_full     = (r_cnt == c_CNT_MAX);
   assign w_empty    = (r_cnt == '0);
   assign w_load     = ~r_c_o_v | ~bus.c_o_bp;
   assign w_deq      = w_load & ~w_empty;
   assign w_hs       = r_c_o_v & ~bus.c_o_bp;
   assign w_rate_hit = ({1'b0, r_lfsr[7:0]} < c_RATE);
   // a full FIFO still accepts when its head leaves in the same cycle
   assign w_attempt  = (r_state == S_RUN) && (r_att != c_LIMIT) && w_rate_hit &&
                       (~w_full || w_deq);
   assign w_go       = start && ((r_state == S_IDLE) || (r_state == S_DONE));

   assign w_unused_ci = ^{bus.c_i[A_W+D_W], bus.c_i[D_W-1:0]};

   // Free-running Galois LFSR
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr <= SEED ^ c_POSV;
      end else begin
         r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? c_LFSR_MSK : 32'h0);
      end
   end

   // Run control: state, attempt counter and done flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_att   <= '0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_go) begin
                  r_state <= S_RUN;
                  r_att   <= '0;
               end
            end
            S_RUN: begin
               if (r_att == c_LIMIT) begin
                  r_state <= S_DRAIN;
               end else if (w_attempt) begin
                  r_att <= r_att + 32'd1;
               end
            end
            S_DRAIN: begin
               if (w_empty && !r_c_o_v) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               if (w_go) begin
                  r_state <= S_RUN;
                  r_att   <= '0;
                  r_done  <= 1'b0;
               end
            end
         endcase
      end
   end

   // Injection FIFO: written by attempts, read when the output register loads
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_attempt) begin
            r_mem[r_wp] <= {w_dest, w_data};
            r_wp        <= r_wp + c_PTR_ONE;
         end
         if (w_deq) begin
            r_rp <= r_rp + c_PTR_ONE;
         end
         case ({w_attempt, w_deq})
            2'b10:   r_cnt <= r_cnt + c_CNT_ONE;
            2'b01:   r_cnt <= r_cnt - c_CNT_ONE;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Output register: reloads when empty or consumed, holds under backpressure
   always_ff @(posedge clk) begin
      if (rst) begin
         r_c_o   <= '0;
         r_c_o_v <= 1'b0;
      end else if (w_load) begin
         r_c_o_v <= ~w_empty;
         if (!w_empty) begin
            r_c_o <= {1'b0, r_mem[r_rp]};
         end
      end
   end

   // Saturating count of packets accepted by the router
   always_ff @(posedge clk) begin
      if (rst || w_go) begin
         r_sent <= '0;
      end else if (w_hs && (r_sent != 32'hFFFF_FFFF)) begin
         r_sent <= r_sent + 32'd1;
      end
   end

   // Receive sink: saturating count and sticky misrouting flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rcvd <= '0;
         r_err  <= 1'b0;
      end else if (bus.c_i_v) begin
         if (r_rcvd != 32'hFFFF_FFFF) begin
            r_rcvd <= r_rcvd + 32'd1;
         end
         if (bus.c_i[A_W+D_W-1:D_W] != A_W'(POSX)) begin
            r_err <= 1'b1;
         end
      end
   end

   assign bus.c_i_bp = 1'b0;
   assign bus.c_o    = r_c_o;
   assign bus.c_o_v  = r_c_o_v;
   assign sent_cnt   = r_sent;
   assign rcvd_cnt   = r_rcvd;
   assign err        = r_err;
   assign done       = r_done;
endmodule
`default_nettype wire
